// File: rtl/mcpu_io_pkg.sv
// Shared definitions for the MCPU I/O controller: register map, register bit
// positions and the bundle of asynchronous inputs that share one synchroniser.
package mcpu_io_pkg;

  // Register indices within the I/O window
  localparam logic [2:0] REG_STATUS    = 3'd0;
  localparam logic [2:0] REG_KEY       = 3'd1;
  localparam logic [2:0] REG_PADDLE    = 3'd2;
  localparam logic [2:0] REG_FRAME_CNT = 3'd3;
  localparam logic [2:0] REG_IRQ_EN    = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;

  // STATUS bit positions
  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_VSF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  // IRQ_EN bit positions
  localparam int unsigned IRQ_EN_KEY   = 0;
  localparam int unsigned IRQ_EN_VSYNC = 1;
  localparam int unsigned IRQ_EN_W     = 2;

  // CTRL bit positions
  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 2;
  localparam int unsigned CTRL_CLR_VSF = 3;

  localparam int unsigned KEY_W    = 8;
  localparam int unsigned PADDLE_W = 8;

  // Asynchronous inputs, synchronised together as one bundle
  typedef struct packed {
    logic                vsync;
    logic [KEY_W-1:0]    keycode;
    logic [PADDLE_W-1:0] hpaddle;
    logic [PADDLE_W-1:0] vpaddle;
  } io_async_t;

endpackage

// File: rtl/mcpu_sync_fifo.sv
// Synchronous FIFO with push/pop/flush.
//   clk, rst_n      : clock, async active-low reset
//   push, din       : write request and data (dropped when full without pop)
//   pop             : read request (ignored when empty)
//   flush           : empty the FIFO; a same-cycle push survives as sole entry
//   dout_c          : head entry (combinational read of storage)
//   full, empty     : registered flags
//   count           : registered occupancy 0..DEPTH
//   overflow_c      : push dropped this cycle
module mcpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt, wr_idx_c;
  logic [CNT_W-1:0] cnt_nxt;
  logic             do_push_c, do_pop_c;

  // Pop needs data; a full FIFO still accepts a push if a pop or flush frees room
  assign do_pop_c   = pop & ~empty & ~flush;
  assign do_push_c  = push & (~full | do_pop_c | flush);
  assign overflow_c = push & full & ~do_pop_c & ~flush;
  assign wr_idx_c   = flush ? '0 : wr_ptr;
  assign dout_c     = mem[rd_ptr];

  // Next pointer/count state
  always_comb begin
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = count;
    if (flush) begin
      rd_nxt  = '0;
      wr_nxt  = PTR_W'(do_push_c);
      cnt_nxt = CNT_W'(do_push_c);
    end else begin
      if (do_push_c) wr_nxt = wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_nxt = rd_ptr + PTR_W'(1);
      cnt_nxt = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  // Pointers, count and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= cnt_nxt;
      full   <= (cnt_nxt == CNT_W'(DEPTH));
      empty  <= (cnt_nxt == '0);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_idx_c] <= din;
  end

endmodule

// File: rtl/mcpu_io_ctrl.sv
// MCPU I/O controller: keyboard FIFO, paddles, frame counter, IRQ.
//   clk, reset               : clock, async active-low reset
//   hpaddle, vpaddle         : async paddle inputs
//   keycode                  : async held key code (0 = none)
//   vsync                    : async vertical sync
//   io_sel, io_addr          : I/O window select and register index
//   io_re, io_we, data_in    : read/write strobes and write data
//   data_out, data_oe        : registered read data and its valid
//   sense                    : synchronised vsync level
//   irq                      : registered level interrupt
module mcpu_io_ctrl
  import mcpu_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            hpaddle,
  input  logic [7:0]            vpaddle,
  input  logic [7:0]            keycode,
  input  logic                  vsync,
  input  logic                  io_sel,
  input  logic [2:0]            io_addr,
  input  logic                  io_re,
  input  logic                  io_we,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  sense,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  io_async_t                  async_c, sync1, sync2;
  logic [KEY_W-1:0]           key_prev;
  logic                       vs_prev;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic                       ovf, vsf;
  logic [IRQ_EN_W-1:0]        irq_en;

  logic                       wr_c, rd_c, ctrl_wr_c, push_c, pop_c, flush_c, vs_rise_c;
  logic [KEY_W-1:0]           fifo_head_c;
  logic                       fifo_full, fifo_empty, fifo_ovf_c;
  logic [CNT_W-1:0]           fifo_count;
  logic [DATA_WIDTH-1:0]      status_c, rd_data_c;
  logic                       unused_data_in_c;

  assign async_c = '{vsync: vsync, keycode: keycode, hpaddle: hpaddle, vpaddle: vpaddle};
  assign sense   = sync2.vsync;

  // Bus decode: a simultaneous read+write is treated as a write
  assign wr_c      = io_sel & io_we;
  assign rd_c      = io_sel & io_re & ~io_we;
  assign ctrl_wr_c = wr_c & (io_addr == REG_CTRL);
  assign pop_c     = rd_c & (io_addr == REG_KEY);
  assign flush_c   = ctrl_wr_c & data_in[CTRL_FLUSH];

  // New key press: nonzero and changed since last cycle
  assign push_c    = (sync2.keycode != '0) & (sync2.keycode != key_prev);
  assign vs_rise_c = sync2.vsync & ~vs_prev;

  assign unused_data_in_c = ^data_in[DATA_WIDTH-1:4];

  mcpu_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push_c),
    .pop        (pop_c),
    .flush      (flush_c),
    .din        (sync2.keycode),
    .dout_c     (fifo_head_c),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .overflow_c (fifo_ovf_c)
  );

  // Read data mux
  always_comb begin
    status_c                           = '0;
    status_c[ST_NOT_EMPTY]             = ~fifo_empty;
    status_c[ST_FULL]                  = fifo_full;
    status_c[ST_OVF]                   = ovf;
    status_c[ST_VSF]                   = vsf;
    status_c[ST_COUNT_LSB +: CNT_W]    = fifo_count;
    rd_data_c                          = '0;
    case (io_addr)
      REG_STATUS:    rd_data_c = status_c;
      REG_KEY:       if (!fifo_empty) rd_data_c = DATA_WIDTH'(fifo_head_c);
      REG_PADDLE:    rd_data_c = DATA_WIDTH'({sync2.vpaddle, sync2.hpaddle});
      REG_FRAME_CNT: rd_data_c = DATA_WIDTH'(frame_cnt);
      REG_IRQ_EN:    rd_data_c = DATA_WIDTH'(irq_en);
      default:       rd_data_c = '0;
    endcase
  end

  // Synchronisers, sticky flags, registers and bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      key_prev  <= '0;
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      vsf       <= 1'b0;
      irq_en    <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sync1    <= async_c;
      sync2    <= sync1;
      key_prev <= sync2.keycode;
      vs_prev  <= sync2.vsync;
      if (vs_rise_c) frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
      // Set wins over a same-cycle clear
      ovf <= fifo_ovf_c | (ovf & ~(ctrl_wr_c & data_in[CTRL_CLR_OVF]));
      vsf <= vs_rise_c  | (vsf & ~(ctrl_wr_c & data_in[CTRL_CLR_VSF]));
      if (wr_c && (io_addr == REG_IRQ_EN)) irq_en <= data_in[IRQ_EN_W-1:0];
      data_oe  <= rd_c;
      data_out <= rd_c ? rd_data_c : '0;
      irq      <= (irq_en[IRQ_EN_KEY] & ~fifo_empty) | (irq_en[IRQ_EN_VSYNC] & vsf);
    end
  end

endmodule

// File: tb/tb_mcpu_io_ctrl.sv
// Directed self-checking bench for mcpu_io_ctrl. A second instance with an
// 8-bit frame counter exercises the counter wrap in a short run.
module tb_mcpu_io_ctrl;
  import mcpu_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hpaddle, vpaddle, keycode;
  logic        vsync, vsync2;
  logic        io_sel, io_re, io_we;
  logic [2:0]  io_addr;
  logic [15:0] data_in;
  logic [15:0] data_out, data_out2;
  logic        data_oe, data_oe2, sense, sense2, irq, irq2;

  int errors = 0;
  int checks = 0;
  logic [15:0] rd_val, rd_val2;
  logic        rd_oe;

  always #5 clk = ~clk;

  mcpu_io_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FRAME_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .hpaddle(hpaddle), .vpaddle(vpaddle),
    .keycode(keycode), .vsync(vsync), .io_sel(io_sel), .io_addr(io_addr),
    .io_re(io_re), .io_we(io_we), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .sense(sense), .irq(irq)
  );

  mcpu_io_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FRAME_CNT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .hpaddle(hpaddle), .vpaddle(vpaddle),
    .keycode(keycode), .vsync(vsync2), .io_sel(io_sel), .io_addr(io_addr),
    .io_re(io_re), .io_we(io_we), .data_in(data_in), .data_out(data_out2),
    .data_oe(data_oe2), .sense(sense2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] a);
    io_sel = 1'b1; io_re = 1'b1; io_we = 1'b0; io_addr = a;
    @(posedge clk);
    #1;
    rd_val  = data_out;
    rd_val2 = data_out2;
    rd_oe   = data_oe;
    io_sel = 1'b0; io_re = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rd(a);
    check({tag, ".oe"}, 16'(rd_oe), 16'd1);
    check(tag, rd_val, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    io_sel = 1'b1; io_we = 1'b1; io_re = 1'b0; io_addr = a; data_in = d;
    @(posedge clk);
    #1;
    io_sel = 1'b0; io_we = 1'b0; data_in = '0;
  endtask

  task automatic key(input logic [7:0] k);
    keycode = k;
    tick(3);
  endtask

  task automatic vpulse();
    vsync = 1'b1; tick(3);
    vsync = 1'b0; tick(3);
  endtask

  initial begin
    reset = 1'b0; hpaddle = '0; vpaddle = '0; keycode = '0; vsync = 1'b0; vsync2 = 1'b0;
    io_sel = 1'b0; io_re = 1'b0; io_we = 1'b0; io_addr = '0; data_in = '0;
    tick(3);
    check("rst.data_oe", 16'(data_oe), 16'd0);
    check("rst.data_out", data_out, 16'h0000);
    check("rst.irq", 16'(irq), 16'd0);
    check("rst.sense", 16'(sense), 16'd0);
    check("rst.irq2", 16'(irq2), 16'd0);
    check("rst.sense2", 16'(sense2), 16'd0);
    reset = 1'b1;
    tick(2);
    rd_chk("init.status", REG_STATUS, 16'h0000);
    rd_chk("init.frame", REG_FRAME_CNT, 16'h0000);
    rd_chk("init.irq_en", REG_IRQ_EN, 16'h0000);
    tick(1);
    check("idle.data_oe", 16'(data_oe), 16'd0);
    check("idle.data_out", data_out, 16'h0000);

    // Paddles
    hpaddle = 8'h34; vpaddle = 8'h12; tick(3);
    rd_chk("paddle", REG_PADDLE, 16'h1234);

    // Strobes without io_sel are ignored
    io_sel = 1'b0; io_we = 1'b1; io_addr = REG_IRQ_EN; data_in = 16'h0003; tick(1);
    io_we = 1'b0; io_re = 1'b1; tick(1);
    check("nosel.data_oe", 16'(data_oe), 16'd0);
    io_re = 1'b0; data_in = '0;
    rd_chk("nosel.irq_en", REG_IRQ_EN, 16'h0000);

    // Unmapped addresses
    rd_chk("addr6", 3'd6, 16'h0000);
    wr(3'd7, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    rd_chk("unmapped.status", REG_STATUS, 16'h0000);
    rd_chk("unmapped.irq_en", REG_IRQ_EN, 16'h0000);

    // Held key pushes once per change
    key(8'h41); key(8'h41); key(8'h42); key(8'h00);
    rd_chk("k2.status", REG_STATUS, 16'h0201);
    rd_chk("k2.key0", REG_KEY, 16'h0041);
    rd_chk("k2.key1", REG_KEY, 16'h0042);
    rd_chk("k2.key_empty", REG_KEY, 16'h0000);
    rd_chk("k2.status_after", REG_STATUS, 16'h0000);

    // Nine keys into depth 8: last is dropped, OVF set
    for (int i = 0; i < 9; i++) key(8'h10 + 8'(i));
    key(8'h00);
    rd_chk("ovf.status", REG_STATUS, 16'h0807);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("ovf.key%0d", i), REG_KEY, 16'h0010 + 16'(i));
    rd_chk("ovf.key_empty", REG_KEY, 16'h0000);
    rd_chk("ovf.status_empty", REG_STATUS, 16'h0004);
    wr(REG_CTRL, 16'h0004);
    rd_chk("ovf.cleared", REG_STATUS, 16'h0000);

    // Full FIFO with pop and push in the same cycle
    for (int i = 0; i < 8; i++) key(8'h20 + 8'(i));
    key(8'h00);
    rd_chk("full.status", REG_STATUS, 16'h0803);
    keycode = 8'h28; tick(2);
    rd_chk("full.pop_push_key", REG_KEY, 16'h0020);
    tick(2);
    rd_chk("full.pop_push_status", REG_STATUS, 16'h0803);
    rd_chk("full.next_key", REG_KEY, 16'h0021);
    keycode = 8'h00; tick(3);
    wr(REG_CTRL, 16'h0001);
    rd_chk("flush.status", REG_STATUS, 16'h0000);

    // Flush coincident with push keeps only the pushed key
    keycode = 8'h30; tick(2);
    wr(REG_CTRL, 16'h0001);
    tick(2);
    rd_chk("flushpush.status", REG_STATUS, 16'h0101);
    rd_chk("flushpush.key", REG_KEY, 16'h0030);
    keycode = 8'h00; tick(3);

    // Read and write together is a write
    io_sel = 1'b1; io_re = 1'b1; io_we = 1'b1; io_addr = REG_IRQ_EN; data_in = 16'h0001;
    tick(1);
    io_sel = 1'b0; io_re = 1'b0; io_we = 1'b0; data_in = '0;
    check("rw.data_oe", 16'(data_oe), 16'd0);
    rd_chk("rw.irq_en", REG_IRQ_EN, 16'h0001);
    check("kirq.idle", 16'(irq), 16'd0);
    key(8'h55); key(8'h00);
    check("kirq.set", 16'(irq), 16'd1);
    rd_chk("kirq.key", REG_KEY, 16'h0055);
    tick(1);
    check("kirq.clear", 16'(irq), 16'd0);
    wr(REG_IRQ_EN, 16'h0000);

    // Vsync: sense latency, frame count, VSF and irq
    vsync = 1'b1; tick(1);
    check("sense.lat1", 16'(sense), 16'd0);
    tick(1);
    check("sense.lat2", 16'(sense), 16'd1);
    tick(1);
    vsync = 1'b0; tick(3);
    check("sense.low", 16'(sense), 16'd0);
    vpulse(); vpulse();
    rd_chk("vs.frame", REG_FRAME_CNT, 16'h0003);
    rd_chk("vs.status", REG_STATUS, 16'h0008);
    wr(REG_IRQ_EN, 16'h0002);
    tick(1);
    check("vs.irq_set", 16'(irq), 16'd1);
    rd_chk("vs.irq_en", REG_IRQ_EN, 16'h0002);
    wr(REG_CTRL, 16'h0008);
    check("vs.irq_lag", 16'(irq), 16'd1);
    tick(1);
    check("vs.irq_clear", 16'(irq), 16'd0);
    rd_chk("vs.status_clear", REG_STATUS, 16'h0000);
    wr(REG_IRQ_EN, 16'h0000);

    // VSF set wins over a same-cycle clear
    vsync = 1'b1; tick(2);
    wr(REG_CTRL, 16'h0008);
    vsync = 1'b0; tick(3);
    rd_chk("setwins.status", REG_STATUS, 16'h0008);
    rd_chk("setwins.frame", REG_FRAME_CNT, 16'h0004);
    wr(REG_CTRL, 16'h0008);

    // Frame counter wrap on the 8-bit instance
    for (int i = 0; i < 255; i++) begin
      vsync2 = 1'b1; tick(1);
      vsync2 = 1'b0; tick(1);
    end
    tick(3);
    rd(REG_FRAME_CNT);
    check("wrap.oe2", 16'(data_oe2), 16'd1);
    check("wrap.max", rd_val2, 16'h00FF);
    vsync2 = 1'b1; tick(1);
    vsync2 = 1'b0; tick(3);
    rd(REG_FRAME_CNT);
    check("wrap.zero", rd_val2, 16'h0000);
    check("wrap.main_frame", rd_val, 16'h0004);

    // Reset during a read
    wr(REG_IRQ_EN, 16'h0001);
    key(8'h66); key(8'h00);
    check("prerst.irq", 16'(irq), 16'd1);
    vsync = 1'b1; tick(3);
    check("prerst.sense", 16'(sense), 16'd1);
    io_sel = 1'b1; io_re = 1'b1; io_addr = REG_STATUS;
    @(posedge clk);
    #1;
    check("midrd.oe", 16'(data_oe), 16'd1);
    check("midrd.status", data_out, 16'h0109);
    reset = 1'b0; vsync = 1'b0;
    #1;
    check("midrst.data_oe", 16'(data_oe), 16'd0);
    check("midrst.data_out", data_out, 16'h0000);
    check("midrst.irq", 16'(irq), 16'd0);
    check("midrst.sense", 16'(sense), 16'd0);
    io_sel = 1'b0; io_re = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    rd_chk("postrst.status", REG_STATUS, 16'h0000);
    rd_chk("postrst.frame", REG_FRAME_CNT, 16'h0000);
    rd_chk("postrst.irq_en", REG_IRQ_EN, 16'h0000);
    rd_chk("postrst.key", REG_KEY, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_io_ctrl.md
MCPU_IO_CTRL -- requirements
Module: mcpu_io_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, CPU data bus width (>=16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, key FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter FRAME_CNT_WIDTH, default 16, frame counter width (<=DATA_WIDTH).
REQ-004 SHALL have one clock and an asynchronous active-low reset; port clk, input, 1, system clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports hpaddle and vpaddle, input, 8 each, gamepad/paddle inputs, asynchronous.
REQ-007 SHALL have port keycode, input, 8, held keyboard code (0 = no key), asynchronous.
REQ-008 SHALL have port vsync, input, 1, video vertical sync, asynchronous.
REQ-009 SHALL have port io_sel, input, 1, CPU address falls in I/O window.
REQ-010 SHALL have port io_addr, input, 3, register index within window.
REQ-011 SHALL have ports io_re and io_we, input, 1 each, read/write strobes, qualified by io_sel.
REQ-012 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-014 SHALL have port data_oe, output, 1, data_out valid / bus drive enable.
REQ-015 SHALL have port sense, output, 1, synchronised vsync level for the CPU SENSE input.
REQ-016 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-017 SHALL pass vsync, keycode, hpaddle, vpaddle through 2-flop synchronisers; all logic uses synchronised values only.
REQ-018 SHALL drive sense = synchronised vsync (2-cycle latency).
REQ-019 SHALL push synchronised keycode into the FIFO when it is nonzero and differs from its value on the previous cycle.
REQ-020 SHALL, on push while full with no pop same cycle, drop the new code and set sticky OVF; FIFO contents unchanged.
REQ-021 SHALL, on push and pop in the same cycle (including full), perform both; count unchanged.
REQ-022 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-023 SHALL, on synchronised vsync rising edge, increment FRAME_CNT (wraps to 0 at max) and set sticky VSF.
REQ-024 SHALL map registers: 0 STATUS (RO), 1 KEY (RO, pops), 2 PADDLE (RO), 3 FRAME_CNT (RO), 4 IRQ_EN (RW), 5 CTRL (WO); 6-7 read 0, writes ignored.
REQ-025 SHALL form STATUS as bit0 not-empty, bit1 full, bit2 OVF, bit3 VSF, bits[8+:log2(FIFO_DEPTH)+1] count, others 0.
REQ-026 SHALL return KEY = head code zero-extended and pop one entry; reading KEY when empty returns 0 and pops nothing.
REQ-027 SHALL return PADDLE = {vpaddle_sync, hpaddle_sync} zero-extended.
REQ-028 SHALL use IRQ_EN bit0 = key irq enable, bit1 = vsync irq enable; other bits read 0.
REQ-029 SHALL, on CTRL write, flush FIFO if bit0, clear OVF if bit2, clear VSF if bit3.
REQ-030 SHALL let set win over clear when a VSF/OVF set event and CTRL clear occur in the same cycle; a flush and push in the same cycle leaves exactly the pushed entry.
REQ-031 SHALL register read data: io_sel&io_re in cycle N gives data_out/data_oe=1 in cycle N+1; data_oe=0 and data_out=0 otherwise.
REQ-032 SHALL ignore io_re/io_we when io_sel=0; io_re and io_we both high treats the access as a write.
REQ-033 SHALL drive irq = (IRQ_EN[0] & not-empty) | (IRQ_EN[1] & VSF), registered (1-cycle latency).

Reset
REQ-034 SHALL, on reset low, asynchronously clear synchronisers, FIFO pointers/count, OVF, VSF, FRAME_CNT, IRQ_EN, previous-keycode register; data_out=0, data_oe=0, irq=0, sense=0.
REQ-035 SHALL discard an in-flight read when reset asserts mid-operation; no pop takes effect.

Structure
REQ-036 SHALL place register indices, STATUS/IRQ_EN/CTRL bit positions in shared package mcpu_io_pkg.
REQ-037 SHALL implement the key FIFO as sub-module mcpu_sync_fifo (parametrised width/depth, push/pop/flush, full/empty/count).

Verification
REQ-038 SHALL cover: keycode 0->0x41->0x41->0x42->0 -> FIFO holds 0x41,0x42; two KEY reads return 0x41,0x42; third returns 0.
REQ-039 SHALL cover: 9 distinct keys, depth 8, no reads -> STATUS full=1, OVF=1, count=8; KEY reads return first 8 codes.
REQ-040 SHALL cover: full FIFO, KEY read coincident with new push -> count stays 8, OVF stays 0.
REQ-041 SHALL cover: 3 vsync pulses -> FRAME_CNT=3, VSF=1; IRQ_EN=2 -> irq=1; CTRL write 0x8 -> VSF=0, irq=0 one cycle later.
REQ-042 SHALL cover: FRAME_CNT at 0xFFFF + vsync edge -> 0x0000; read of STATUS then reset low mid-read -> data_oe=0 immediately, all registers 0.
